// File: rtl/jt6295_mix_pkg.sv
// Shared definitions for the jt6295 voice mixer.
// Holds the clog2 helper, the accumulator width function and the pass FSM state type.
// Imported by jt6295_mix; jt6295_mix_sat needs nothing from here.
package jt6295_mix_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ceiling log2; clog2(1) = 0 so a single channel or RATE=1 adds no bits.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Headroom for CH channels times RATE passes plus one guard bit.
  function automatic int acc_w(input int inw, input int ch, input int rate);
    return inw + clog2(ch) + clog2(rate) + 1;
  endfunction

endpackage

// File: rtl/jt6295_mix_sat.sv
// Signed saturator from IW to OW bits with a clip flag (combinational).
// Ports: din (IW signed) -> dout (OW signed); clip = 1 when din does not fit in OW.
// When OW >= IW the value is only sign-extended and clip stays 0.
module jt6295_mix_sat #(
  parameter int IW = 18,
  parameter int OW = 17
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 clip
);

  generate
    if (IW > OW) begin : g_narrow
      // Fits when every bit above the OW sign position equals the sign bit.
      always_comb begin
        if (din[IW-1:OW-1] == {(IW-OW+1){din[IW-1]}}) begin
          dout = din[OW-1:0];
          clip = 1'b0;
        end else begin
          dout = {din[IW-1], {(OW-1){~din[IW-1]}}};
          clip = 1'b1;
        end
      end
    end else begin : g_wide
      assign dout = OW'(din);
      assign clip = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/jt6295_mix.sv
// Serial CH-voice ADPCM mixer: sums channels once per cen_sub, integrates a frame, saturates to OUTW.
// Ports: clk/rst (async, active-high); cen/cen_sub strobes; sound_in/ch_mute inputs;
//        sound_out, sample, busy, overrun (sticky), clip (sticky) outputs.
// Optional JT6295_MIX_INTERPOL_EN: linear interpolation between frames, one output per cen_sub.
module jt6295_mix
  import jt6295_mix_pkg::*;
#(
  parameter int CH   = 4,
  parameter int INW  = 12,
  parameter int OUTW = 14,
  parameter int RATE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   cen_sub,
  input  logic [CH*INW-1:0]      sound_in,
  input  logic [CH-1:0]          ch_mute,
  output logic signed [OUTW-1:0] sound_out,
  output logic                   sample,
  output logic                   busy,
  output logic                   overrun,
  output logic                   clip
);

  localparam int ACCW = acc_w(INW, CH, RATE);
  localparam int IDXW = (CH > 1) ? clog2(CH) : 1;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] frame_q, frame_d;
  logic                   load_q, load_d;   // output stage updates on the next clk
  logic signed [OUTW-1:0] sound_out_q, sound_out_d;
  logic                   sample_q, sample_d;
  logic                   overrun_q, overrun_d;
  logic                   clip_q, clip_d;

  logic signed [INW-1:0]  ch_sel;
  logic signed [ACCW:0]   ch_ext;
  logic signed [ACCW:0]   acc_sum;
  logic signed [ACCW-1:0] acc_sat;
  logic                   acc_clip;
  logic signed [OUTW-1:0] out_sat;
  logic                   out_clip;

  // Channel under the current serial index, muted channels contribute 0.
  always_comb begin
    ch_sel  = sound_in[int'(idx_q)*INW +: INW];
    ch_ext  = ch_sel;
    if (ch_mute[idx_q]) ch_ext = '0;
    acc_sum = $signed({acc_q[ACCW-1], acc_q}) + ch_ext;
  end

  jt6295_mix_sat #(.IW(ACCW+1), .OW(ACCW)) u_acc_sat (
    .din  (acc_sum),
    .dout (acc_sat),
    .clip (acc_clip)
  );

`ifdef JT6295_MIX_INTERPOL_EN
  localparam int LR  = clog2(RATE);
  localparam int KW  = LR + 1;
  localparam int IPW = ACCW + LR + 3;

  logic signed [ACCW-1:0] prev_q, prev_d;
  logic [KW-1:0]          k_q, k_d;     // strobes since the last cen, 1..RATE
  logic signed [IPW-1:0]  diff, prod, interp;

  // prev + k*(cur-prev)/RATE with the division as an arithmetic shift.
  always_comb begin
    diff   = IPW'(frame_q) - IPW'(prev_q);
    prod   = diff * $signed({1'b0, k_q});
    interp = (prod >>> LR) + IPW'(prev_q);
  end

  jt6295_mix_sat #(.IW(IPW), .OW(OUTW)) u_out_sat (
    .din  (interp),
    .dout (out_sat),
    .clip (out_clip)
  );
`else
  jt6295_mix_sat #(.IW(ACCW), .OW(OUTW)) u_out_sat (
    .din  (frame_q),
    .dout (out_sat),
    .clip (out_clip)
  );
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    frame_d     = frame_q;
    load_d      = 1'b0;
    overrun_d   = overrun_q;
    clip_d      = clip_q;
    sound_out_d = sound_out_q;
    sample_d    = 1'b0;
`ifdef JT6295_MIX_INTERPOL_EN
    prev_d      = prev_q;
    k_d         = k_q;
`endif

    case (state_q)
      IDLE: begin
        if (cen_sub) begin
          state_d = RUN;
          idx_d   = '0;
          // Frame boundary: latch the finished total, new pass starts from zero.
          if (cen) begin
            frame_d = acc_q;
            acc_d   = '0;
          end
`ifdef JT6295_MIX_INTERPOL_EN
          if (cen) begin
            prev_d = frame_q;
            k_d    = KW'(1);
          end else if (k_q != KW'(RATE)) begin
            k_d = k_q + KW'(1);
          end
          load_d = 1'b1;
`else
          load_d = cen;
`endif
        end
      end
      RUN: begin
        acc_d = acc_sat;
        if (acc_clip) clip_d = 1'b1;
        // A strobe arriving mid-pass is dropped but remembered.
        if (cen_sub) overrun_d = 1'b1;
        if (idx_q == IDXW'(CH-1)) state_d = IDLE;
        else                      idx_d   = idx_q + IDXW'(1);
      end
    endcase

    if (load_q) begin
      sound_out_d = out_sat;
      sample_d    = 1'b1;
      if (out_clip) clip_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      frame_q     <= '0;
      load_q      <= 1'b0;
      sound_out_q <= '0;
      sample_q    <= 1'b0;
      overrun_q   <= 1'b0;
      clip_q      <= 1'b0;
`ifdef JT6295_MIX_INTERPOL_EN
      prev_q      <= '0;
      k_q         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      frame_q     <= frame_d;
      load_q      <= load_d;
      sound_out_q <= sound_out_d;
      sample_q    <= sample_d;
      overrun_q   <= overrun_d;
      clip_q      <= clip_d;
`ifdef JT6295_MIX_INTERPOL_EN
      prev_q      <= prev_d;
      k_q         <= k_d;
`endif
    end
  end

  assign sound_out = sound_out_q;
  assign sample    = sample_q;
  assign busy      = (state_q == RUN);
  assign overrun   = overrun_q;
  assign clip      = clip_q;

endmodule
